// File: rtl/s_feeder.sv
// s_feeder: packs the serial 2-bit query stream S into PE-array-wide chunks and returns one per request.
// Define S_FEEDER_DOUBLE_BUF_EN to add a second (ping-pong) chunk buffer so filling overlaps a waiting chunk.
module s_feeder #(
    parameter int PE_ARRAY_SIZE     = 64,
    parameter int PE_ARRAY_SIZE_LOG = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_sym_valid,
    input  logic [1:0]                   i_sym,
    input  logic                         i_sym_last,
    output logic                         o_sym_ready,
    input  logic                         i_request_s,
    output logic [2*PE_ARRAY_SIZE-1:0]   o_s,
    output logic [PE_ARRAY_SIZE_LOG:0]   o_s_valid,
    output logic                         o_s_ack,
    output logic                         o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int             CW       = PE_ARRAY_SIZE_LOG + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(PE_ARRAY_SIZE);

`ifdef S_FEEDER_DOUBLE_BUF_EN
    localparam logic [1:0] NBUF   = 2'd2;
    localparam logic       TOGGLE = 1'b1;
`else
    localparam logic [1:0] NBUF   = 2'd1;
    localparam logic       TOGGLE = 1'b0;
`endif

    logic [1:0]                 state, state_n;
    logic [2*PE_ARRAY_SIZE-1:0] chunk_buf [2];
    logic [CW-1:0]              cnt_buf [2];
    logic [CW-1:0]              wr_cnt, cnt_inc, ack_cnt;
    logic                       wr_idx, rd_idx, ack_buf;
    logic [1:0]                 n_full, n_full_n;
    logic                       last_flag, last_flag_n;
    logic                       end_flag, end_flag_n;
    logic                       pending, pending_n;
    logic                       accept, complete, req_any, free_buf;
    logic                       serve_buf, serve_bypass, serve_zero, serve;
    logic                       busy_n;
    logic [2*PE_ARRAY_SIZE-1:0] fill_chunk, ack_data, ack_mask;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        accept   = o_sym_ready && i_sym_valid;
        cnt_inc  = wr_cnt + CW'(1);
        complete = accept && ((cnt_inc == FULL_CNT) || i_sym_last);

        fill_chunk = chunk_buf[wr_idx];
        fill_chunk[{wr_cnt[PE_ARRAY_SIZE_LOG-1:0], 1'b0} +: 2] = i_sym;

        // A chunk stays owned until its ack cycle ends, so only one ack is ever in flight.
        req_any      = (i_request_s || pending) && (state != S_IDLE) && !o_s_ack;
        serve_buf    = req_any && (n_full != 2'd0);
        serve_bypass = req_any && (n_full == 2'd0) && complete;
        serve_zero   = req_any && (state == S_DONE);
        serve        = serve_buf || serve_bypass || serve_zero;
        free_buf     = o_s_ack && ack_buf;

        ack_cnt  = '0;
        ack_data = '0;
        if (serve_buf) begin
            ack_cnt  = cnt_buf[rd_idx];
            ack_data = chunk_buf[rd_idx];
        end else if (serve_bypass) begin
            ack_cnt  = cnt_inc;
            ack_data = fill_chunk;
        end
        ack_mask = '0;
        for (int k = 0; k < PE_ARRAY_SIZE; k++) begin
            ack_mask[2*k +: 2] = (k < int'(ack_cnt)) ? 2'b11 : 2'b00;
        end

        if (i_start) begin
            n_full_n    = '0;
            last_flag_n = 1'b0;
            end_flag_n  = 1'b0;
            pending_n   = 1'b0;
            state_n     = S_FILL;
        end else begin
            n_full_n    = n_full + {1'b0, complete} - {1'b0, free_buf};
            last_flag_n = last_flag || (complete && i_sym_last);
            // A full final chunk owes the processor a trailing zero-count chunk.
            end_flag_n  = (end_flag || (complete && i_sym_last && (cnt_inc == FULL_CNT))) && !serve_zero;
            pending_n   = (i_request_s || pending) && (state != S_IDLE) && !serve;
            if (state == S_IDLE)
                state_n = S_IDLE;
            else if (last_flag_n && (n_full_n == 2'd0))
                state_n = S_DONE;
            else if (last_flag_n || (n_full_n == NBUF))
                state_n = S_FULL;
            else
                state_n = S_FILL;
        end

        busy_n = (state_n != S_IDLE) && !((state_n == S_DONE) && !end_flag_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_cnt      <= '0;
            wr_idx      <= 1'b0;
            rd_idx      <= 1'b0;
            n_full      <= '0;
            last_flag   <= 1'b0;
            end_flag    <= 1'b0;
            pending     <= 1'b0;
            ack_buf     <= 1'b0;
            // NOTE: the chunk buffers are plain registers, so resetting them is cheap and keeps o_s deterministic.
            for (int b = 0; b < 2; b++) begin
                chunk_buf[b] <= '0;
                cnt_buf[b]   <= '0;
            end
            o_sym_ready <= 1'b0;
            o_s         <= '0;
            o_s_valid   <= '0;
            o_s_ack     <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees the pre-edge values.
            state       <= state_n;
            n_full      <= n_full_n;
            last_flag   <= last_flag_n;
            end_flag    <= end_flag_n;
            pending     <= pending_n;
            o_sym_ready <= (state_n == S_FILL);
            o_busy      <= busy_n;
            o_s_ack     <= serve && !i_start;
            o_s         <= (serve && !i_start) ? (ack_data & ack_mask) : '0;
            o_s_valid   <= (serve && !i_start) ? ack_cnt : '0;
            ack_buf     <= (serve_buf || serve_bypass) && !i_start;

            if (i_start) begin
                wr_cnt <= '0;
                wr_idx <= 1'b0;
                rd_idx <= 1'b0;
                for (int b = 0; b < 2; b++) begin
                    chunk_buf[b] <= '0;
                    cnt_buf[b]   <= '0;
                end
            end else begin
                if (accept) begin
                    chunk_buf[wr_idx] <= fill_chunk;
                    if (complete) begin
                        cnt_buf[wr_idx] <= cnt_inc;
                        wr_cnt          <= '0;
                        wr_idx          <= wr_idx ^ TOGGLE;
                    end else begin
                        wr_cnt <= cnt_inc;
                    end
                end
                if (free_buf)
                    rd_idx <= rd_idx ^ TOGGLE;
            end
        end
    end

endmodule

// File: tb/tb_s_feeder.sv
// Scoreboard bench for s_feeder: stimulus pushes expected chunks, a negedge monitor pops and compares on every ack.
module tb_s_feeder;
    localparam int N   = 64;
    localparam int LOG = 6;
    localparam logic [2*N-1:0] CHUNK_E4 = {16{8'hE4}};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_start = 1'b0;
    logic           i_sym_valid = 1'b0;
    logic [1:0]     i_sym = 2'b00;
    logic           i_sym_last = 1'b0;
    logic           i_request_s = 1'b0;
    logic           o_sym_ready, o_s_ack, o_busy;
    logic [2*N-1:0] o_s;
    logic [LOG:0]   o_s_valid;

    typedef struct {
        logic [LOG:0]   cnt;
        logic [2*N-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   ack_count = 0;

    always #5 clk = ~clk;

    s_feeder #(.PE_ARRAY_SIZE(N), .PE_ARRAY_SIZE_LOG(LOG)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_sym_valid (i_sym_valid),
        .i_sym       (i_sym),
        .i_sym_last  (i_sym_last),
        .o_sym_ready (o_sym_ready),
        .i_request_s (i_request_s),
        .o_s         (o_s),
        .o_s_valid   (o_s_valid),
        .o_s_ack     (o_s_ack),
        .o_busy      (o_busy)
    );

    task automatic check(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_s_ack === 1'b1) begin
            ack_count++;
            check("ack_outstanding", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("ack_count", 128'(o_s_valid), 128'(mon_e.cnt));
                check("ack_data", o_s, mon_e.data);
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic send_syms(input int n, input int first, input bit last_at_end, output int stalls);
        int budget;
        stalls = 0;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            i_sym_valid = 1'b1;
            i_sym       = 2'((first + i) % 4);
            i_sym_last  = last_at_end && (i == n - 1);
            budget      = 0;
            @(negedge clk);
            while (o_sym_ready !== 1'b1 && budget < 300) begin
                stalls++;
                budget++;
                @(negedge clk);
            end
            if (o_sym_ready !== 1'b1) begin
                check("sym_ready_timeout", 128'(o_sym_ready), 128'(1));
                i_sym_valid = 1'b0;
                i_sym_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        i_sym_valid = 1'b0;
        i_sym_last  = 1'b0;
    endtask

    task automatic do_request(input bit expect_ack, input logic [LOG:0] cnt, input logic [2*N-1:0] data,
                              output int waited);
        exp_t e;
        waited = 0;
        @(posedge clk); #1;
        if (expect_ack) begin
            e.cnt  = cnt;
            e.data = data;
            sb.push_back(e);
        end
        i_request_s = 1'b1;
        @(posedge clk); #1;
        i_request_s = 1'b0;
        if (expect_ack) begin
            @(negedge clk);
            while (o_s_ack !== 1'b1 && waited < 300) begin
                waited++;
                @(negedge clk);
            end
            check("ack_arrived", 128'(o_s_ack), 128'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, w, saved;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 128'(o_sym_ready), 128'(0));
        check("rst_busy",  128'(o_busy), 128'(0));
        check("rst_ack",   128'(o_s_ack), 128'(0));
        check("rst_valid", 128'(o_s_valid), 128'(0));
        check("rst_s",     o_s, 128'(0));

        // Exactly 64 symbols, last on the 64th: full chunk then zero-count end chunk
        pulse_start();
        @(negedge clk);
        check("start_ready", 128'(o_sym_ready), 128'(1));
        check("start_busy",  128'(o_busy), 128'(1));
        send_syms(64, 0, 1'b1, st);
        check("t1_stalls", 128'(st), 128'(0));
        @(negedge clk);
        check("t1_ready_full", 128'(o_sym_ready), 128'(0));
        do_request(1'b1, 7'd64, CHUNK_E4, w);
        check("t1_ack1_latency", 128'(w), 128'(0));
        do_request(1'b1, 7'd0, 128'(0), w);
        check("t1_ack2_latency", 128'(w), 128'(0));
        @(negedge clk);
        check("t1_busy_end", 128'(o_busy), 128'(0));

        // 70 symbols: counts 64 then 6, then DONE answers with a zero chunk
        pulse_start();
        fork
            send_syms(70, 0, 1'b1, st);
            begin
                int w1, w2;
                do_request(1'b1, 7'd64, CHUNK_E4, w1);
                do_request(1'b1, 7'd6, 128'h4E4, w2);
            end
        join
        @(negedge clk);
        check("t2_busy_end", 128'(o_busy), 128'(0));
        do_request(1'b1, 7'd0, 128'(0), w);
        check("t2_done_latency", 128'(w), 128'(0));

        // Request while only 10 symbols are loaded: ack one cycle after symbol 64
        pulse_start();
        send_syms(10, 0, 1'b0, st);
        fork
            do_request(1'b1, 7'd64, CHUNK_E4, w);
            begin
                int st2;
                send_syms(54, 10, 1'b0, st2);
                @(negedge clk);
                check("t3_pending_ack", 128'(o_s_ack), 128'(1));
                check("t3_ready_low", 128'(o_sym_ready), 128'(0));
            end
        join

        // i_start mid-fill drops the pending request; a fresh 5-symbol sequence returns count 5
        pulse_start();
        send_syms(30, 0, 1'b0, st);
        do_request(1'b0, '0, '0, w);
        pulse_start();
        @(negedge clk);
        check("t4_ready", 128'(o_sym_ready), 128'(1));
        check("t4_busy", 128'(o_busy), 128'(1));
        send_syms(5, 0, 1'b1, st);
        do_request(1'b1, 7'd5, 128'h0E4, w);
        check("t4_ack_latency", 128'(w), 128'(0));
        @(negedge clk);
        check("t4_busy_end", 128'(o_busy), 128'(0));

        // Asynchronous reset while a chunk waits
        pulse_start();
        send_syms(64, 0, 1'b0, st);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("t5_rst_ready", 128'(o_sym_ready), 128'(0));
        check("t5_rst_busy",  128'(o_busy), 128'(0));
        check("t5_rst_ack",   128'(o_s_ack), 128'(0));
        check("t5_rst_valid", 128'(o_s_valid), 128'(0));
        check("t5_rst_s",     o_s, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        saved = ack_count;
        do_request(1'b0, '0, '0, w);
        repeat (5) @(negedge clk);
        check("t5_no_ack", 128'(ack_count), 128'(saved));
        check("t5_idle_ready", 128'(o_sym_ready), 128'(0));

`ifdef S_FEEDER_DOUBLE_BUF_EN
        // Ping-pong: 128 symbols stream without stalls, chunks come back in fill order
        pulse_start();
        send_syms(128, 0, 1'b1, st);
        check("db_stalls", 128'(st), 128'(0));
        @(negedge clk);
        check("db_ready_low", 128'(o_sym_ready), 128'(0));
        do_request(1'b1, 7'd64, CHUNK_E4, w);
        do_request(1'b1, 7'd64, CHUNK_E4, w);
        do_request(1'b1, 7'd0, 128'(0), w);
        @(negedge clk);
        check("db_busy_end", 128'(o_busy), 128'(0));
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
